// File: rtl/instr_encoder.sv
// Instruction encoder: turns high-level commands into program-memory bytes.
// Single-byte ops (LOAD/MOV/ALU/NOP) are emitted one cycle after acceptance.
// JMP/JNZ expand into three bytes (x0 load, y0 load, jump). The first two
// bytes overwrite x0 and y0 as a side effect.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no expansion in progress; commands accepted, at most one byte out
// JX0   | presenting the x0 load byte (addr[3:0])
// JY0   | presenting the y0 load byte (addr[7:4])
// JOP   | presenting the final jump byte (addr[9:8], JMP/JNZ opcode)
module instr_encoder (
   input  logic       clk,
   input  logic       sync_reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [2:0] cmd_dst,
   input  logic [2:0] cmd_src,
   input  logic [3:0] cmd_data,
   input  logic       cmd_x,
   input  logic       cmd_y,
   input  logic [2:0] cmd_fn,
   input  logic [9:0] cmd_addr,
   output logic [7:0] instr,
   output logic       instr_valid,
   input  logic       instr_ready,
   output logic [9:0] pm_addr,
   output logic       err,
   output logic       wrap
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      JX0  = 2'd1,
      JY0  = 2'd2,
      JOP  = 2'd3
   } state_t;

   localparam logic [2:0] OP_LOAD = 3'd0;
   localparam logic [2:0] OP_MOV  = 3'd1;
   localparam logic [2:0] OP_ALU  = 3'd2;
   localparam logic [2:0] OP_JMP  = 3'd3;
   localparam logic [2:0] OP_JNZ  = 3'd4;
   localparam logic [2:0] OP_NOP  = 3'd5;

   state_t     r_state;
   logic [7:0] r_instr;
   logic       r_valid;
   logic [9:0] r_pm_addr;
   logic       r_err;
   logic       r_wrap;
   logic [5:0] r_addr_hi;
   logic       r_jnz;

   logic       w_accept;
   logic       w_consume;
   logic [7:0] w_byte;
   logic       w_jump;
   logic       w_illegal;

   // Ready only when idle and the output slot is free or being drained now
   assign cmd_ready = (r_state == IDLE) && (!r_valid || instr_ready) && !sync_reset;
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_consume = r_valid && instr_ready;

   assign instr       = r_instr;
   assign instr_valid = r_valid;
   assign pm_addr     = r_pm_addr;
   assign err         = r_err;
   assign wrap        = r_wrap;

   // First byte of the incoming command; fields unused by the op are ignored
   always_comb begin
      w_byte    = 8'hC8;
      w_jump    = 1'b0;
      w_illegal = 1'b0;
      case (cmd_op)
         OP_LOAD: w_byte = {1'b0, cmd_dst, cmd_data};
         OP_MOV:  w_byte = {2'b10, cmd_dst, cmd_src};
         OP_ALU:  w_byte = {3'b110, cmd_x, cmd_y, cmd_fn};
         OP_JMP,
         OP_JNZ: begin
            w_jump = 1'b1;
            w_byte = {4'h0, cmd_addr[3:0]};
         end
         OP_NOP:  w_byte = 8'hC8;
         default: w_illegal = 1'b1;
      endcase
   end

   // Sequencer, output byte register, address counter and sticky flags
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         r_state   <= IDLE;
         r_instr   <= 8'h00;
         r_valid   <= 1'b0;
         r_pm_addr <= 10'd0;
         r_err     <= 1'b0;
         r_wrap    <= 1'b0;
         r_addr_hi <= 6'd0;
         r_jnz     <= 1'b0;
      end else begin
         if (w_consume) begin
            r_pm_addr <= r_pm_addr + 10'd1;
            if (r_pm_addr == 10'd1023) begin
               r_wrap <= 1'b1;
            end
         end
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_illegal) begin
                     // slot was empty or is being drained this cycle
                     r_err   <= 1'b1;
                     r_valid <= 1'b0;
                  end else begin
                     r_instr <= w_byte;
                     r_valid <= 1'b1;
                     if (w_jump) begin
                        r_addr_hi <= cmd_addr[9:4];
                        r_jnz     <= (cmd_op == OP_JNZ);
                        r_state   <= JX0;
                     end
                  end
               end else if (w_consume) begin
                  r_valid <= 1'b0;
               end
            end
            JX0: begin
               if (w_consume) begin
                  r_instr <= {4'h2, r_addr_hi[3:0]};
                  r_state <= JY0;
               end
            end
            JY0: begin
               if (w_consume) begin
                  r_instr <= {(r_jnz ? 4'hF : 4'hE), 2'b00, r_addr_hi[5:4]};
                  r_state <= JOP;
               end
            end
            JOP: begin
               if (w_consume) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table vectors, directed corner sequences and a
// randomized run, all checked against a byte-queue reference model.
module tb_instr_encoder;

   logic       clk = 1'b0;
   logic       sync_reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [2:0] cmd_dst;
   logic [2:0] cmd_src;
   logic [3:0] cmd_data;
   logic       cmd_x;
   logic       cmd_y;
   logic [2:0] cmd_fn;
   logic [9:0] cmd_addr;
   logic [7:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic [9:0] pm_addr;
   logic       err;
   logic       wrap;

   instr_encoder dut (
      .clk         (clk),
      .sync_reset  (sync_reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_dst     (cmd_dst),
      .cmd_src     (cmd_src),
      .cmd_data    (cmd_data),
      .cmd_x       (cmd_x),
      .cmd_y       (cmd_y),
      .cmd_fn      (cmd_fn),
      .cmd_addr    (cmd_addr),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pm_addr     (pm_addr),
      .err         (err),
      .wrap        (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       v;
      bit [2:0] op;
      bit [2:0] dst;
      bit [2:0] src;
      bit [3:0] data;
      bit       x;
      bit       y;
      bit [2:0] fn;
      bit [9:0] addr;
   } cmd_t;

   typedef struct {
      cmd_t     c;
      int       n;
      bit [7:0] b[3];
   } vec_t;

   typedef struct {
      bit [7:0] b;
      bit       j;
   } qe_t;

   int  total = 0;
   int  bad   = 0;
   bit  primed = 0;

   // reference model state
   qe_t q[$];
   int  m_pm   = 0;
   bit  m_err  = 0;
   bit  m_wrap = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic cmd_t mk(input int op, input int dst, input int src, input int data,
                               input int x, input int y, input int fn, input int addr);
      cmd_t c;
      c.v = 1; c.op = op[2:0]; c.dst = dst[2:0]; c.src = src[2:0]; c.data = data[3:0];
      c.x = x[0]; c.y = y[0]; c.fn = fn[2:0]; c.addr = addr[9:0];
      return c;
   endfunction

   function automatic cmd_t idle_cmd();
      cmd_t c;
      c = mk($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom);
      c.v = 0;
      return c;
   endfunction

   function automatic bit m_ready(input bit rdy, input bit rst);
      if (rst) return 0;
      if (q.size() == 0) return 1;
      return !q[0].j && rdy;
   endfunction

   // model: what bytes does a command produce, straight from the encoding rules
   task automatic m_push(input cmd_t c);
      qe_t e;
      int  a;
      a = int'(c.addr);
      e.j = 0;
      case (c.op)
         3'd0: begin e.b = 8'(c.dst * 16 + c.data); q.push_back(e); end
         3'd1: begin e.b = 8'(128 + c.dst * 8 + c.src); q.push_back(e); end
         3'd2: begin e.b = 8'(192 + c.x * 16 + c.y * 8 + c.fn); q.push_back(e); end
         3'd5: begin e.b = 8'hC8; q.push_back(e); end
         3'd3, 3'd4: begin
            e.j = 1;
            e.b = 8'(a % 16);                  q.push_back(e);
            e.b = 8'(32 + (a / 16) % 16);      q.push_back(e);
            e.b = 8'(((c.op == 3'd4) ? 240 : 224) + a / 256); q.push_back(e);
         end
         default: m_err = 1;
      endcase
   endtask

   task automatic m_step(input cmd_t c, input bit rdy, input bit rst);
      bit acc;
      if (rst) begin
         q.delete();
         m_pm = 0; m_err = 0; m_wrap = 0;
      end else begin
         acc = c.v && m_ready(rdy, rst);
         if (q.size() > 0 && rdy) begin
            void'(q.pop_front());
            if (m_pm == 1023) m_wrap = 1;
            m_pm = (m_pm + 1) % 1024;
         end
         if (acc) m_push(c);
      end
   endtask

   // one clock: drive at negedge, compare against model, advance model
   task automatic drive(input cmd_t c, input bit rdy, input bit rst);
      @(negedge clk);
      cmd_valid = c.v; cmd_op = c.op; cmd_dst = c.dst; cmd_src = c.src;
      cmd_data = c.data; cmd_x = c.x; cmd_y = c.y; cmd_fn = c.fn; cmd_addr = c.addr;
      instr_ready = rdy; sync_reset = rst;
      #1;
      if (primed) begin
         chk("valid", int'(instr_valid), int'(q.size() > 0));
         if (q.size() > 0) chk("instr", int'(instr), int'(q[0].b));
         chk("pm_addr", int'(pm_addr), m_pm);
         chk("err", int'(err), int'(m_err));
         chk("wrap", int'(wrap), int'(m_wrap));
         chk("cmd_ready", int'(cmd_ready), int'(m_ready(rdy, rst)));
      end
      m_step(c, rdy, rst);
   endtask

   task automatic do_reset();
      drive(idle_cmd(), 1'b0, 1'b1);
      primed = 1;
   endtask

   vec_t vecs[7];

   initial begin
      cmd_t c;
      int   exp_pm;

      vecs[0].c = mk(0, 5, 6, 'hA, 1, 1, 7, 'h3FF); vecs[0].n = 1; vecs[0].b = '{8'h5A, 8'h00, 8'h00};
      vecs[1].c = mk(1, 4, 4, 0, 0, 0, 0, 0);       vecs[1].n = 1; vecs[1].b = '{8'hA4, 8'h00, 8'h00};
      vecs[2].c = mk(1, 1, 7, 5, 1, 1, 1, 'h155);   vecs[2].n = 1; vecs[2].b = '{8'h8F, 8'h00, 8'h00};
      vecs[3].c = mk(2, 6, 2, 9, 1, 0, 3, 'h2AA);   vecs[3].n = 1; vecs[3].b = '{8'hD3, 8'h00, 8'h00};
      vecs[4].c = mk(5, 7, 7, 15, 1, 1, 7, 'h3FF);  vecs[4].n = 1; vecs[4].b = '{8'hC8, 8'h00, 8'h00};
      vecs[5].c = mk(3, 3, 3, 3, 0, 1, 2, 'h2B7);   vecs[5].n = 3; vecs[5].b = '{8'h07, 8'h2B, 8'hE2};
      vecs[6].c = mk(4, 0, 0, 0, 0, 0, 0, 'h2B7);   vecs[6].n = 3; vecs[6].b = '{8'h07, 8'h2B, 8'hF2};

      sync_reset = 1; cmd_valid = 0; instr_ready = 0;
      cmd_op = 0; cmd_dst = 0; cmd_src = 0; cmd_data = 0;
      cmd_x = 0; cmd_y = 0; cmd_fn = 0; cmd_addr = 0;

      do_reset();
      drive(idle_cmd(), 1'b0, 1'b0);
      chk("rst_valid", int'(instr_valid), 0);
      chk("rst_instr", int'(instr), 0);
      chk("rst_pm", int'(pm_addr), 0);

      // table vectors, each drained fully before the next command
      exp_pm = 0;
      foreach (vecs[i]) begin
         drive(vecs[i].c, 1'b1, 1'b0);
         for (int k = 0; k < vecs[i].n; k++) begin
            drive(idle_cmd(), 1'b1, 1'b0);
            chk("tbl_instr", int'(instr), int'(vecs[i].b[k]));
            chk("tbl_pm", int'(pm_addr), exp_pm);
            if (vecs[i].n == 3) chk("tbl_jmp_ready", int'(cmd_ready), 0);
            exp_pm++;
         end
      end
      drive(idle_cmd(), 1'b1, 1'b0);
      chk("tbl_drained", int'(instr_valid), 0);

      // stall: byte and address held, no new command accepted
      do_reset();
      drive(mk(0, 0, 5, 3, 0, 0, 0, 0), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(mk(1, 2, 3, 0, 0, 0, 0, 0), 1'b0, 1'b0);
         chk("stall_instr", int'(instr), 'h03);
         chk("stall_pm", int'(pm_addr), 0);
         chk("stall_ready", int'(cmd_ready), 0);
      end
      drive(idle_cmd(), 1'b1, 1'b0);
      drive(idle_cmd(), 1'b1, 1'b0);
      chk("stall_after_pm", int'(pm_addr), 1);
      chk("stall_after_valid", int'(instr_valid), 0);

      // illegal op: sticky err, nothing emitted, address untouched
      drive(mk(6, 1, 1, 1, 1, 1, 1, 1), 1'b1, 1'b0);
      drive(idle_cmd(), 1'b1, 1'b0);
      chk("ill_err", int'(err), 1);
      chk("ill_valid", int'(instr_valid), 0);
      chk("ill_pm", int'(pm_addr), 1);
      drive(mk(5, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
      drive(idle_cmd(), 1'b1, 1'b0);
      drive(idle_cmd(), 1'b1, 1'b0);
      chk("ill_sticky", int'(err), 1);

      // 1025 NOPs back-to-back wrap the address
      do_reset();
      for (int k = 0; k < 1025; k++) drive(mk(5, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
      drive(idle_cmd(), 1'b1, 1'b0);
      drive(idle_cmd(), 1'b1, 1'b0);
      chk("wrap_flag", int'(wrap), 1);
      chk("wrap_pm", int'(pm_addr), 1);

      // reset in JY0 drops the rest of the expansion
      do_reset();
      drive(mk(3, 0, 0, 0, 0, 0, 0, 'h2B7), 1'b1, 1'b0);
      drive(idle_cmd(), 1'b1, 1'b0);
      drive(idle_cmd(), 1'b0, 1'b0);
      chk("jy0_instr", int'(instr), 'h2B);
      drive(idle_cmd(), 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         drive(idle_cmd(), 1'b1, 1'b0);
         chk("jrst_valid", int'(instr_valid), 0);
         chk("jrst_pm", int'(pm_addr), 0);
      end
      chk("jrst_flags", int'({err, wrap}), 0);

      // randomized traffic, including occasional resets and illegal ops
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         c = mk($urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom);
         if ($urandom_range(0, 9) < 2 && c.op > 3'd5) c.op = 3'd3;
         c.v = ($urandom_range(0, 9) < 7);
         drive(c, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
